// File: rtl/wb_arbiter.sv
// wb_arbiter: merges register-file write requests from three result sources
// (alu, fpu, mem) into the single core write port.
//
// Each source owns a FIFO_DEPTH-entry queue holding {fmode, rd, data}. At most
// one entry is popped per cycle from the granted non-empty queue. The popped
// entry is registered onto the write port on the same edge as the pop.
//
// Build option:
//   WB_ARBITER_RR_EN  defined   -> round-robin grant, order alu -> fpu -> mem -> alu
//                     undefined -> fixed priority mem > fpu > alu, no rotation state
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   <s>_valid/_ready             per-source push handshake (s = alu, fpu, mem)
//   <s>_fmode/_rd/_data          per-source entry: file select, register, value
//   wenable/wfmode/wreg/wdata    registered register-file write port
//   idle                         all queues empty and no write strobe this cycle

module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic        alu_fmode,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,

  input  logic        fpu_valid,
  output logic        fpu_ready,
  input  logic        fpu_fmode,
  input  logic [4:0]  fpu_rd,
  input  logic [31:0] fpu_data,

  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_fmode,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,

  output logic        wenable,
  output logic        wfmode,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  output logic        idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NS = 3;  // source index: 0 alu, 1 fpu, 2 mem
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic        fmode;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  // Source-indexed views of the ports
  logic   [NS-1:0] valid;
  logic   [NS-1:0] ready;
  entry_t          in_entry [NS];

  assign valid       = {mem_valid, fpu_valid, alu_valid};
  assign in_entry[0] = '{fmode: alu_fmode, rd: alu_rd, data: alu_data};
  assign in_entry[1] = '{fmode: fpu_fmode, rd: fpu_rd, data: fpu_data};
  assign in_entry[2] = '{fmode: mem_fmode, rd: mem_rd, data: mem_data};

  assign alu_ready = ready[0];
  assign fpu_ready = ready[1];
  assign mem_ready = ready[2];

  // Queue state: wrap-around pointers carry one extra bit to tell full from empty
  entry_t          mem_q  [NS][FIFO_DEPTH];
  logic   [AW:0]   wptr_q [NS];
  logic   [AW:0]   rptr_q [NS];
  logic   [NS-1:0] empty;
  logic   [NS-1:0] full;
  logic   [NS-1:0] push;
  logic   [NS-1:0] gnt;

  // Cleared by reset, set the cycle after release; holds ready low through
  // reset without a combinational path from rstn to the ready outputs.
  logic            run_q;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NS; i++) begin
      empty[i] = (wptr_q[i] == rptr_q[i]);
      full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                 (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
    end
  end

  // Ready depends only on registered state
  assign ready = {NS{run_q}} & ~full;
  assign push  = valid & ready;

  // Grant selection
`ifdef WB_ARBITER_RR_EN
  // rr_q names the source the next search starts from
  logic [1:0]  rr_q;
  logic [1:0]  gnt_idx;

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = 2'd0;
    idx     = 0;
    found   = 1'b0;
    for (int k = 0; k < NS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NS) idx = idx - NS;
      if (!found && !empty[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = 2'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_q <= 2'd0;
    end else if (|gnt) begin
      rr_q <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
  end
`else
  always_comb begin
    gnt = '0;
    if (!empty[2]) begin
      gnt[2] = 1'b1;
    end else if (!empty[1]) begin
      gnt[1] = 1'b1;
    end else if (!empty[0]) begin
      gnt[0] = 1'b1;
    end
  end
`endif

  // Head of the granted queue
  entry_t pop_entry;
  logic   pop_write;

  always_comb begin
    pop_entry = '0;
    for (int i = 0; i < NS; i++) begin
      if (gnt[i]) pop_entry = mem_q[i][rptr_q[i][AW-1:0]];
    end
  end

  // Integer x0 is hardwired zero: pop the entry but never strobe it
  assign pop_write = (|gnt) && (pop_entry.fmode || (pop_entry.rd != 5'd0));

  // Queue storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (push[i]) mem_q[i][wptr_q[i][AW-1:0]] <= in_entry[i];
    end
  end

  logic        wenable_q;
  logic        wfmode_q;
  logic [4:0]  wreg_q;
  logic [31:0] wdata_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_q     <= 1'b0;
      wenable_q <= 1'b0;
      wfmode_q  <= 1'b0;
      wreg_q    <= 5'd0;
      wdata_q   <= 32'd0;
      for (int i = 0; i < NS; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      for (int i = 0; i < NS; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PTR_ONE;
        if (gnt[i])  rptr_q[i] <= rptr_q[i] + PTR_ONE;
      end
      // Strobe is a single-cycle pulse; the data fields hold when nothing is written
      wenable_q <= pop_write;
      if (pop_write) begin
        wfmode_q <= pop_entry.fmode;
        wreg_q   <= pop_entry.rd;
        wdata_q  <= pop_entry.data;
      end
    end
  end

  assign wenable = wenable_q;
  assign wfmode  = wfmode_q;
  assign wreg    = wreg_q;
  assign wdata   = wdata_q;
  assign idle    = (&empty) && !wenable_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default build, FIFO_DEPTH = 2).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_valid, alu_ready, alu_fmode;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        fpu_valid, fpu_ready, fpu_fmode;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        mem_valid, mem_ready, mem_fmode;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wenable, wfmode, idle;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_fmode (alu_fmode),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .fpu_valid (fpu_valid),
    .fpu_ready (fpu_ready),
    .fpu_fmode (fpu_fmode),
    .fpu_rd    (fpu_rd),
    .fpu_data  (fpu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_fmode (mem_fmode),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wenable   (wenable),
    .wfmode    (wfmode),
    .wreg      (wreg),
    .wdata     (wdata),
    .idle      (idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    alu_valid = 1'b0; alu_fmode = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    fpu_valid = 1'b0; fpu_fmode = 1'b0; fpu_rd = 5'd0; fpu_data = 32'd0;
    mem_valid = 1'b0; mem_fmode = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_wenable", 32'(wenable), 32'd0);
    check("rst_wreg", 32'(wreg), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wfmode", 32'(wfmode), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    rstn = 1'b1;
    tick();
    check("rel_idle", 32'(idle), 32'd1);
    check("rel_alu_ready", 32'(alu_ready), 32'd1);
    check("rel_fpu_ready", 32'(fpu_ready), 32'd1);

    // Single alu write, two edges of latency
    alu_valid = 1'b1; alu_fmode = 1'b0; alu_rd = 5'd5; alu_data = 32'h0000_002A;
    tick();
    alu_valid = 1'b0;
    check("single_wen_e1", 32'(wenable), 32'd0);
    check("single_idle_e1", 32'(idle), 32'd0);
    tick();
    check("single_wen_e2", 32'(wenable), 32'd1);
    check("single_wreg", 32'(wreg), 32'd5);
    check("single_wdata", wdata, 32'h0000_002A);
    check("single_wfmode", 32'(wfmode), 32'd0);
    tick();
    check("single_wen_e3", 32'(wenable), 32'd0);
    check("single_idle_e3", 32'(idle), 32'd1);
    check("single_hold_wreg", 32'(wreg), 32'd5);

    // Simultaneous push: mem, then fpu, then alu
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    fpu_valid = 1'b1; fpu_rd = 5'd2; fpu_data = 32'h22; fpu_fmode = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    tick();
    alu_valid = 1'b0; fpu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    check("prio_1_wen", 32'(wenable), 32'd1);
    check("prio_1_wreg", 32'(wreg), 32'd3);
    check("prio_1_wdata", wdata, 32'h33);
    tick();
    check("prio_2_wreg", 32'(wreg), 32'd2);
    check("prio_2_wfmode", 32'(wfmode), 32'd1);
    tick();
    check("prio_3_wreg", 32'(wreg), 32'd1);
    check("prio_3_wen", 32'(wenable), 32'd1);
    tick();
    check("prio_done_wen", 32'(wenable), 32'd0);
    check("prio_done_idle", 32'(idle), 32'd1);

    // Integer x0 suppressed, float f0 written
    alu_valid = 1'b1; alu_fmode = 1'b0; alu_rd = 5'd0; alu_data = 32'h55;
    tick();
    alu_fmode = 1'b1; alu_rd = 5'd0; alu_data = 32'h3F80_0000;
    tick();
    alu_valid = 1'b0;
    check("x0_wen", 32'(wenable), 32'd0);
    tick();
    check("f0_wen", 32'(wenable), 32'd1);
    check("f0_wfmode", 32'(wfmode), 32'd1);
    check("f0_wreg", 32'(wreg), 32'd0);
    check("f0_wdata", wdata, 32'h3F80_0000);
    tick();
    check("f0_after_wen", 32'(wenable), 32'd0);

    // mem streams continuously and starves alu until it stops
    mem_valid = 1'b1; mem_fmode = 1'b0; mem_rd = 5'd20; mem_data = 32'h200;
    alu_valid = 1'b1; alu_fmode = 1'b0; alu_rd = 5'd7; alu_data = 32'h107;
    tick();
    alu_rd = 5'd8; alu_data = 32'h108;
    check("starve_ready_1", 32'(alu_ready), 32'd1);
    tick();
    check("starve_mem_wen", 32'(wenable), 32'd1);
    check("starve_mem_wreg", 32'(wreg), 32'd20);
    alu_rd = 5'd9; alu_data = 32'h109;
    check("starve_ready_full", 32'(alu_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("starve_loop_wreg", 32'(wreg), 32'd20);
      check("starve_loop_ready", 32'(alu_ready), 32'd0);
    end
    mem_valid = 1'b0;
    tick();
    check("starve_last_mem", 32'(wreg), 32'd20);
    tick();
    check("starve_alu0_wreg", 32'(wreg), 32'd7);
    check("starve_alu0_wdata", wdata, 32'h107);
    check("starve_ready_back", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("starve_alu1_wreg", 32'(wreg), 32'd8);
    tick();
    check("starve_alu2_wreg", 32'(wreg), 32'd9);
    check("starve_alu2_wdata", wdata, 32'h109);
    tick();
    check("starve_end_idle", 32'(idle), 32'd1);

    // Reset with queues loaded: nothing stale may be written afterwards
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hA11;
    fpu_valid = 1'b1; fpu_rd = 5'd12; fpu_data = 32'hF12;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hE13;
    tick();
    tick();
    tick();
    check("pre_rst_alu_full", 32'(alu_ready), 32'd0);
    check("pre_rst_fpu_full", 32'(fpu_ready), 32'd0);
    rstn = 1'b0;
    tick();
    alu_valid = 1'b0; fpu_valid = 1'b0; mem_valid = 1'b0;
    check("mid_rst_wen", 32'(wenable), 32'd0);
    check("mid_rst_ready", 32'(mem_ready), 32'd0);
    rstn = 1'b1;
    tick();
    check("post_rst_wen", 32'(wenable), 32'd0);
    check("post_rst_idle", 32'(idle), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_stale", 32'(wenable), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
